// File: rtl/lif_iterate_core.sv
// ----------------------------------------------------------------------------
// lif_iterate_core: time-multiplexed leaky integrate-and-fire layer, one neuron per cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lif_iterate_core #(
  parameter int N          = 16,
  parameter int W_WIDTH    = 3,
  parameter int V_WIDTH    = 8,
  parameter int LEAK_SHIFT = 2,
  parameter int THRESH     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       spike_in,
  input  logic                       w_we,
  input  logic [$clog2(N)-1:0]       w_addr,
  input  logic signed [W_WIDTH-1:0]  w_data,
  input  logic [$clog2(N)-1:0]       v_sel,
  output logic signed [V_WIDTH-1:0]  v_out,
  output logic                       busy,
  output logic                       done,
  output logic [N-1:0]               spike_out
);

  localparam int c_aw = $clog2(N);
  localparam int c_vx = V_WIDTH + 2;
  localparam logic signed [c_vx-1:0]    c_vmax   = c_vx'((2 ** (V_WIDTH - 1)) - 1);
  localparam logic signed [c_vx-1:0]    c_vmin   = c_vx'(-(2 ** (V_WIDTH - 1)));
  localparam logic signed [V_WIDTH-1:0] c_thresh = V_WIDTH'(THRESH);
  localparam logic [c_aw-1:0]           c_last   = c_aw'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [c_aw-1:0]            r_idx;
  logic                       r_spk;
  logic [N-1:0]               r_fire;
  logic signed [V_WIDTH-1:0]  r_v [N];
  logic signed [W_WIDTH-1:0]  r_w [N];

  logic signed [c_vx-1:0]     w_vx;
  logic signed [c_vx-1:0]     w_wx;
  logic signed [c_vx-1:0]     w_leak;
  logic signed [c_vx-1:0]     w_sum;
  logic signed [V_WIDTH-1:0]  w_vsat;
  logic                       w_fire;

  // Shared datapath: operands always come from the neuron currently addressed by r_idx
  assign w_vx = {{2{r_v[r_idx][V_WIDTH-1]}}, r_v[r_idx]};
  assign w_wx = {{(c_vx - W_WIDTH){r_w[r_idx][W_WIDTH-1]}}, r_w[r_idx]};

  generate
    if (LEAK_SHIFT == 0) begin : g_no_leak
      assign w_leak = '0;
    end else begin : g_leak
      assign w_leak = w_vx >>> LEAK_SHIFT;
    end
  endgenerate

  assign w_sum = w_vx - w_leak + (r_spk ? w_wx : '0);

  always_comb begin
    w_vsat = w_sum[V_WIDTH-1:0];
    if (w_sum > c_vmax) begin
      w_vsat = c_vmax[V_WIDTH-1:0];
    end else if (w_sum < c_vmin) begin
      w_vsat = c_vmin[V_WIDTH-1:0];
    end
  end

  assign w_fire = (w_vsat >= c_thresh);

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_idx == c_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_spk     <= 1'b0;
      r_fire    <= '0;
      spike_out <= '0;
      for (int i = 0; i < N; i++) begin
        r_v[i] <= '0;
        r_w[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      // A write landing on the neuron being processed takes effect after this cycle
      if (w_we && (int'(w_addr) < N)) begin
        r_w[w_addr] <= w_data;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_spk  <= spike_in;
            r_fire <= '0;
            r_idx  <= '0;
          end
        end
        S_RUN: begin
          if (w_fire) begin
            r_v[r_idx]    <= '0;
            r_fire[r_idx] <= 1'b1;
          end else begin
            r_v[r_idx] <= w_vsat;
          end
          r_idx <= r_idx + 1'b1;
        end
        S_DONE: begin
          spike_out <= r_fire;
        end
        default: begin
        end
      endcase
    end
  end

  assign v_out = r_v[v_sel];

endmodule

`default_nettype wire

// File: doc/lif_iterate_core.md
LIF_ITERATE_CORE -- requirements
Module: lif_iterate_core

Interface
REQ-001 The block SHALL have parameter N, default 16, number of neurons (≥2).
REQ-002 The block SHALL have parameter W_WIDTH, default 3, signed weight width.
REQ-003 The block SHALL have parameter V_WIDTH, default 8, signed membrane width (> W_WIDTH).
REQ-004 The block SHALL have parameter LEAK_SHIFT, default 2, leak arithmetic right-shift (0 = no leak).
REQ-005 The block SHALL have parameter THRESH, default 10, signed firing threshold (V_WIDTH bits).
REQ-006 The block SHALL have port clk, input, 1 bit, sole clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit, begin one timestep.
REQ-009 The block SHALL have port spike_in, input, 1 bit, input spike for the timestep, sampled with start.
REQ-010 The block SHALL have ports w_we, w_addr ($clog2(N)) and w_data (W_WIDTH, signed), all inputs, weight write port.
REQ-011 The block SHALL have port v_sel, input, $clog2(N) bits, membrane readback select.
REQ-012 The block SHALL have port v_out, output, V_WIDTH bits, signed, combinational V[v_sel].
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-014 The block SHALL have port done, output, 1 bit, one-cycle pulse at end of timestep.
REQ-015 The block SHALL have port spike_out, output, N bits, registered firing vector of the last completed timestep.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE; IDLE→RUN on start; RUN→DONE when idx==N-1 processed; DONE→IDLE unconditionally.
REQ-017 On start in IDLE: latch spike_in, clear internal fire vector, idx=0; start SHALL be ignored in RUN/DONE.
REQ-018 In RUN, exactly one neuron idx SHALL be updated per cycle through one shared datapath; idx increments by 1.
REQ-019 Update: Vn = V - leak + (spk ? sext(W[idx]) : 0), where leak = V >>> LEAK_SHIFT (0 when LEAK_SHIFT==0), computed at V_WIDTH+2 bits.
REQ-020 Vn SHALL saturate to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1] before the threshold compare.
REQ-021 If saturated Vn ≥ THRESH, the block SHALL write V[idx]=0 and set fire[idx]=1; otherwise it SHALL write V[idx]=Vn.
REQ-022 In DONE: spike_out<=fire vector (final bit included), done=1 for exactly that cycle.
REQ-023 Latency: start sampled at edge t → done high in cycle t+N+1; busy high cycles t+1..t+N+1.
REQ-024 A weight write SHALL be accepted in any state; a write to W[idx] in the cycle idx is processed SHALL take effect afterwards (old weight used).
REQ-025 A write with w_addr ≥ N SHALL be ignored.
REQ-026 spike_out SHALL hold its value between done pulses.

Reset
REQ-027 rst SHALL force state IDLE, idx=0, all V=0, all W=0, fire=0, spike_out=0, busy=0, done=0 on the next edge.
REQ-028 rst SHALL override start and w_we issued in the same cycle.
REQ-029 rst mid-RUN SHALL abort the timestep without a done pulse and with spike_out=0.

Verification
REQ-030 Defaults, after reset, start with spike_in=0 → done exactly 17 cycles after start edge, spike_out=0, all v_out=0.
REQ-031 Defaults, W[0]=3, five timesteps with spike_in=1 → V0 = 3,6,8,9, then fire; spike_out[0]=1 only after timestep 5, V0=0; timestep 6 → V0=3, spike_out[0]=0.
REQ-032 Defaults, W[1]=-4, spike_in=1 each timestep → V1 = -4,-7,-9,-10,-11,-12,-13,-13 (leak steady state), no fire.
REQ-033 N=4, V_WIDTH=4, THRESH=7, W[0]=-4, spike_in=1 → V0 = -4,-7,-8,-8 (negative saturation).
REQ-034 Second start asserted 3 cycles after the first → ignored, single done pulse; a w_we to W[5] in the cycle idx==5 → old weight used this timestep, new weight next timestep.
REQ-035 rst asserted 5 cycles into RUN → busy=0 next cycle, no done pulse, all v_out=0, spike_out=0.
